modulo_product_par: RTL and testbench
=====================================

MODULO_PRODUCT_PAR -- requirements
Module: modulo_product_par

Interface
REQ-001 Parameter WIDTH, default 256, operand/modulus/result width in bits (>=8).
REQ-002 Parameter ITERS, default 4, shift-add iterations per CALC cycle (1..16).
REQ-003 Parameter K_W, default 11, width of k port.
REQ-004 clk  in  1  single clock; all flops on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operand set offered.
REQ-007 in_ready  out  1  block can accept; high only in IDLE.
REQ-008 N  in  WIDTH  modulus.
REQ-009 a  in  WIDTH  multiplier, consumed LSB first.
REQ-010 b  in  WIDTH  multiplicand, must satisfy b < N.
REQ-011 k  in  K_W  highest bit index of a processed.
REQ-012 abort  in  1  cancel current operation.
REQ-013 out_valid  out  1  result/err valid.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 result  out  WIDTH  a[k:0]*b mod N.
REQ-016 err  out  1  operands illegal (N==0 or b>=N); result forced 0.

Function
REQ-017 States IDLE, CALC, DONE; handshake in_valid&&in_ready in cycle T latches N, a, b, k_eff=min(k,WIDTH-1); t=b, m=0, bit index=0.
REQ-018 If N==0 or b>=N at acceptance: next state DONE with err=1, result=0, no CALC cycles.
REQ-019 Per iteration at index i<=k_eff: if a[i], m=m+t, then m-=N if m>=N; t=2t, then t-=N if t>=N; indices >k_eff leave m, t unchanged.
REQ-020 Internal m, t and sums held at WIDTH+2 bits; no truncation before compare with zero-extended N.
REQ-021 Each CALC cycle chains exactly ITERS iterations combinationally; index advances by ITERS.
REQ-022 CALC lasts C=ceil((k_eff+1)/ITERS) cycles (T+1..T+C); DONE entered at T+C+1 with out_valid=1, result=m[WIDTH-1:0].
REQ-023 In DONE, result/err/out_valid held stable until out_valid&&out_ready; transfer returns to IDLE next cycle.
REQ-024 in_ready=1 in IDLE only; back-to-back: new operands may be accepted the cycle after the output transfer.
REQ-025 abort in CALC or DONE: next state IDLE, out_valid=0, no result produced; abort in IDLE ignored; abort beats out_ready in same cycle.
REQ-026 result equals a[k_eff:0]*b mod N for every legal operand set, any ITERS.

Reset
REQ-027 rst high at a clock edge: state=IDLE, out_valid=0, err=0, result=0, m=t=0, counters=0; in_ready=1 the cycle after rst deasserts.
REQ-028 rst mid-CALC or mid-DONE discards the operation; no out_valid pulse follows.

Structure
REQ-029 Package modprod_pkg holds state enum (IDLE/CALC/DONE) and helper constant functions (cycle count, index width).
REQ-030 Sub-module modprod_step: one combinational iteration (m,t,N,a_bit,enable -> m',t'), instantiated ITERS times via generate.
REQ-031 Iteration counter width = clog2(WIDTH)+1; no latches, all combinational outputs defaulted.

Verification
REQ-032 WIDTH=8, ITERS=2: N=13, a=5, b=7, k=7 accepted at T -> out_valid at T+5, result=9, err=0.
REQ-033 WIDTH=8, ITERS=2: N=13, a=5, b=7, k=2 -> out_valid at T+3, result=9; k=0 -> result=7.
REQ-034 Defaults: N=2^255+1, a=b=N-1, k=255 -> out_valid at T+65, result=1; N=0 -> out_valid at T+1, err=1, result=0.
REQ-035 out_ready held low 10 cycles in DONE -> result/out_valid stable; in_ready stays 0 until transfer+1.
REQ-036 abort at T+2 of REQ-032 op -> IDLE at T+3, no out_valid; rst at T+2 -> same, in_ready=1 after release.
REQ-037 Random 1000 legal operand sets per ITERS in {1,3,4,8} vs reference model; all results match.

Source files
------------

// File: rtl/modprod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : modprod_pkg
//  Description : Shared types and constant helpers for the modular
//                shift-add product engine (state encoding, counter width,
//                CALC cycle count).
//  Revision    : 1.0 - initial release
// ============================================================================
package modprod_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit index counter width: large enough to hold WIDTH itself.
    function automatic int idx_width(input int width);
        return $clog2(width) + 1;
    endfunction

    // Number of CALC cycles needed to cover bit indices 0..k_eff.
    function automatic int calc_cycles(input int k_eff, input int iters);
        return (k_eff + iters) / iters;
    endfunction

endpackage
`default_nettype wire

// File: rtl/modprod_step.sv
`default_nettype none
// ============================================================================
//  Module      : modprod_step
//  Description : One combinational shift-add iteration of the modular
//                product.  When enabled:
//                  m' = (m + a_bit*t) reduced once by N
//                  t' = (2t)          reduced once by N
//                When disabled both values pass through unchanged.
//  Ports       : m_i/t_i   running sum / shifted multiplicand (WIDTH+2)
//                n_i       modulus (WIDTH)
//                a_bit_i   current multiplier bit
//                en_i      iteration enable (index within k_eff)
//                m_o/t_o   updated values (WIDTH+2)
//  Revision    : 1.0 - initial release
// ============================================================================
module modprod_step
    import modprod_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH+1:0] m_i,
    input  logic [WIDTH+1:0] t_i,
    input  logic [WIDTH-1:0] n_i,
    input  logic             a_bit_i,
    input  logic             en_i,
    output logic [WIDTH+1:0] m_o,
    output logic [WIDTH+1:0] t_o
);

    logic [WIDTH+1:0] w_n_ext;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH+1:0] w_sum_red;
    logic [WIDTH+1:0] w_dbl;
    logic [WIDTH+1:0] w_dbl_red;

    // m and t are both < N, so m+t and 2t are < 2N and one conditional
    // subtraction restores the invariant.  Two guard bits keep the carry.
    always_comb begin
        w_n_ext   = {2'b00, n_i};
        w_sum     = a_bit_i ? (m_i + t_i) : m_i;
        w_sum_red = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
        w_dbl     = {t_i[WIDTH:0], 1'b0};
        w_dbl_red = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
        m_o       = en_i ? w_sum_red : m_i;
        t_o       = en_i ? w_dbl_red : t_i;
    end

endmodule
`default_nettype wire

// File: rtl/modulo_product_par.sv
`default_nettype none
// ============================================================================
//  Module      : modulo_product_par
//  Description : Iterative modular multiplier computing a[k:0]*b mod N with
//                ITERS shift-add steps chained per clock.  Ready/valid
//                handshake on input and output, abort and error flagging
//                for illegal operands (N==0 or b>=N).
//  Ports       : clk, rst (sync, active-high)
//                in_valid/in_ready, N, a, b, k    operand side
//                abort                            cancel current operation
//                out_valid/out_ready, result, err result side
//  Revision    : 1.0 - initial release
// ============================================================================
module modulo_product_par
    import modprod_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int ITERS = 4,
    parameter int K_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [K_W-1:0]   k,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam int MW    = WIDTH + 2;

    state_e             state_q, state_d;
    logic [MW-1:0]      m_q, m_d;
    logic [MW-1:0]      t_q, t_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   a_q, a_d;      // multiplier, shifted right ITERS per cycle
    logic [IDX_W-1:0]   idx_q, idx_d;  // bit index of a_q[0]
    logic [IDX_W-1:0]   keff_q, keff_d;
    logic               err_q, err_d;

    logic [MW-1:0]      w_m [0:ITERS];
    logic [MW-1:0]      w_t [0:ITERS];
    logic [ITERS-1:0]   w_en;
    logic [ITERS-1:0]   w_abit;
    logic               w_last;
    logic               w_k_big;
    logic [K_W+31:0]    w_k_ext;
    logic [IDX_W-1:0]   w_keff;

    // Clamp k to WIDTH-1 using a comparison wide enough for any K_W.
    assign w_k_ext = {32'd0, k};
    assign w_k_big = w_k_ext > (K_W+32)'(WIDTH - 1);
    assign w_keff  = w_k_big ? IDX_W'(WIDTH - 1) : IDX_W'(k);

    // Final CALC cycle: this cycle's window reaches past k_eff.
    assign w_last  = (32'(idx_q) + 32'(ITERS)) > 32'(keff_q);

    assign w_m[0] = m_q;
    assign w_t[0] = t_q;

    generate
        for (genvar j = 0; j < ITERS; j++) begin : g_iter
            if (j < WIDTH) begin : g_abit_in
                assign w_abit[j] = a_q[j];
            end else begin : g_abit_pad
                assign w_abit[j] = 1'b0;
            end

            assign w_en[j] = (32'(idx_q) + 32'(j)) <= 32'(keff_q);

            modprod_step #(
                .WIDTH (WIDTH)
            ) u_step (
                .m_i     (w_m[j]),
                .t_i     (w_t[j]),
                .n_i     (n_q),
                .a_bit_i (w_abit[j]),
                .en_i    (w_en[j]),
                .m_o     (w_m[j+1]),
                .t_o     (w_t[j+1])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        t_d     = t_q;
        n_d     = n_q;
        a_d     = a_q;
        idx_d   = idx_q;
        keff_d  = keff_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d    = N;
                    a_d    = a;
                    keff_d = w_keff;
                    idx_d  = '0;
                    m_d    = '0;
                    t_d    = {2'b00, b};
                    // b >= N also covers N == 0.
                    if (b >= N) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    m_d     = w_m[ITERS];
                    t_d     = w_t[ITERS];
                    a_d     = a_q >> ITERS;
                    idx_d   = idx_q + IDX_W'(ITERS);
                    if (w_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            t_q     <= '0;
            n_q     <= '0;
            a_q     <= '0;
            idx_q   <= '0;
            keff_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            t_q     <= t_d;
            n_q     <= n_d;
            a_q     <= a_d;
            idx_q   <= idx_d;
            keff_q  <= keff_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = m_q[WIDTH-1:0];
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_modulo_product_par.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modulo_product_par
//  Description : Self-checking bench for modulo_product_par.  Directed
//                cases on an 8-bit/ITERS=2 instance, the 256-bit default
//                instance, and randomized operands on four 16-bit
//                instances (ITERS 1,3,4,8) against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modulo_product_par;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // a[k_eff:0]*b mod n, k_eff = min(k, w-1); operands up to 16 bits.
    function automatic logic [63:0] ref_mod(input logic [63:0] av, input logic [63:0] bv,
                                            input logic [63:0] nv, input int kv, input int w);
        int          keff;
        logic [63:0] mask;
        keff = (kv > w - 1) ? w - 1 : kv;
        mask = (64'd1 << (keff + 1)) - 64'd1;
        return ((av & mask) * bv) % nv;
    endfunction

    // ---------------- 8-bit, ITERS=2 instance ----------------
    logic [7:0]  n8 = '0, a8 = '0, b8 = '0, res8;
    logic [10:0] k8 = '0;
    logic        iv8 = 1'b0, ab8 = 1'b0, or8 = 1'b0, ir8, ov8, err8;

    modulo_product_par #(.WIDTH(8), .ITERS(2), .K_W(11)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .N(n8), .a(a8), .b(b8),
        .k(k8), .abort(ab8), .out_valid(ov8), .out_ready(or8), .result(res8), .err(err8)
    );

    // ---------------- default 256-bit instance ----------------
    logic [255:0] n2 = '0, a2 = '0, b2 = '0, res2;
    logic [10:0]  k2 = '0;
    logic         iv2 = 1'b0, ab2 = 1'b0, or2 = 1'b0, ir2, ov2, err2;

    modulo_product_par u_dut256 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .N(n2), .a(a2), .b(b2),
        .k(k2), .abort(ab2), .out_valid(ov2), .out_ready(or2), .result(res2), .err(err2)
    );

    // ---------------- random 16-bit instances, shared inputs ----------------
    logic [15:0] nr = 16'd1, ar = '0, br = '0;
    logic [10:0] kr = '0;
    logic        ivr = 1'b0, abr = 1'b0, orr = 1'b0;
    logic        irr [4];
    logic        ovr [4];
    logic        errr [4];
    logic [15:0] resr [4];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_rnd
            localparam int ITG = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 8;
            modulo_product_par #(.WIDTH(16), .ITERS(ITG), .K_W(11)) u_dut (
                .clk(clk), .rst(rst), .in_valid(ivr), .in_ready(irr[g]), .N(nr), .a(ar),
                .b(br), .k(kr), .abort(abr), .out_valid(ovr[g]), .out_ready(orr),
                .result(resr[g]), .err(errr[g])
            );
        end
    endgenerate

    // ---------------- helpers for the 8-bit instance ----------------
    task automatic start8(input logic [7:0] n, input logic [7:0] av, input logic [7:0] bv,
                          input logic [10:0] kv);
        @(negedge clk);
        n8 = n; a8 = av; b8 = bv; k8 = kv; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    // Latency 1 = out_valid right after the acceptance edge.
    task automatic wait8(output int lat);
        lat = 1;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take8(input string tag);
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check_eq({tag, "_ov_after"}, ov8, 1'b0);
        check_eq({tag, "_rdy_after"}, ir8, 1'b1);
    endtask

    task automatic run8(input string tag, input logic [7:0] n, input logic [7:0] av,
                        input logic [7:0] bv, input logic [10:0] kv,
                        input logic [7:0] exp_res, input logic exp_err, input int exp_lat);
        int lat;
        check_eq({tag, "_rdy"}, ir8, 1'b1);
        start8(n, av, bv, kv);
        wait8(lat);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, res8, exp_res);
        check_eq({tag, "_err"}, err8, exp_err);
        take8(tag);
    endtask

    // Watch a few cycles for any stray out_valid.
    task automatic quiet8(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ov8) seen = 1'b1;
        end
        check_eq({tag, "_no_ov"}, seen, 1'b0);
    endtask

    initial begin
        int lat;
        logic stable;

        // ---- reset ----
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_rdy8", ir8, 1'b1);
        check_eq("rst_ov8", ov8, 1'b0);
        check_eq("rst_res8", res8, 8'd0);
        check_eq("rst_err8", err8, 1'b0);
        check_eq("rst_rdy256", ir2, 1'b1);
        check_eq("rst_ov256", ov2, 1'b0);

        // ---- basic op with output stall ----
        start8(8'd13, 8'd5, 8'd7, 11'd7);
        wait8(lat);
        check_eq("k7_lat", lat, 5);
        check_eq("k7_res", res8, 8'd9);
        check_eq("k7_err", err8, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!ov8 || res8 !== 8'd9 || ir8 || err8) stable = 1'b0;
        end
        check_eq("stall_stable", stable, 1'b1);
        take8("k7");

        // ---- back-to-back directed ops ----
        run8("k2", 8'd13, 8'd5, 8'd7, 11'd2, 8'd9, 1'b0, 3);
        run8("k0", 8'd13, 8'd5, 8'd7, 11'd0, 8'd7, 1'b0, 2);
        run8("kbig", 8'd13, 8'd5, 8'd7, 11'd2047, 8'd9, 1'b0, 5);
        run8("n0", 8'd0, 8'd5, 8'd7, 11'd7, 8'd0, 1'b1, 1);
        run8("bgen", 8'd5, 8'd3, 8'd7, 11'd7, 8'd0, 1'b1, 1);
        run8("beqn", 8'd7, 8'd3, 8'd7, 11'd7, 8'd0, 1'b1, 1);
        run8("bmax", 8'd251, 8'd200, 8'd250, 11'd7,
             8'(ref_mod(64'd200, 64'd250, 64'd251, 7, 8)), 1'b0, 5);
        run8("amax", 8'd255, 8'd255, 8'd254, 11'd5,
             8'(ref_mod(64'd255, 64'd254, 64'd255, 5, 8)), 1'b0, 4);

        // ---- abort in CALC at T+2 ----
        start8(8'd13, 8'd5, 8'd7, 11'd7);   // now in cycle T+1
        @(posedge clk); #1;                 // cycle T+2
        ab8 = 1'b1;
        @(posedge clk); #1;                 // cycle T+3
        ab8 = 1'b0;
        check_eq("abort_rdy", ir8, 1'b1);
        check_eq("abort_ov", ov8, 1'b0);
        quiet8("abort", 6);

        // ---- abort in DONE beats out_ready ----
        start8(8'd13, 8'd5, 8'd7, 11'd7);
        wait8(lat);
        check_eq("abdone_lat", lat, 5);
        @(negedge clk); ab8 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1; ab8 = 1'b0; or8 = 1'b0;
        check_eq("abdone_ov", ov8, 1'b0);
        check_eq("abdone_rdy", ir8, 1'b1);
        quiet8("abdone", 4);

        // ---- abort in IDLE ignored: operand still accepted ----
        @(negedge clk);
        n8 = 8'd13; a8 = 8'd5; b8 = 8'd7; k8 = 11'd7; iv8 = 1'b1; ab8 = 1'b1;
        @(posedge clk); #1; iv8 = 1'b0; ab8 = 1'b0;
        wait8(lat);
        check_eq("abidle_lat", lat, 5);
        check_eq("abidle_res", res8, 8'd9);
        take8("abidle");

        // ---- reset mid-CALC ----
        start8(8'd13, 8'd5, 8'd7, 11'd7);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rstmid_ov", ov8, 1'b0);
        check_eq("rstmid_res", res8, 8'd0);
        @(posedge clk); #1;
        check_eq("rstmid_rdy", ir8, 1'b1);
        quiet8("rstmid", 6);

        // ---- 256-bit default instance ----
        @(negedge clk);
        n2 = {1'b1, 254'd0, 1'b1};
        a2 = {1'b1, 255'd0};
        b2 = {1'b1, 255'd0};
        k2 = 11'd255; iv2 = 1'b1;
        @(posedge clk); #1; iv2 = 1'b0;
        lat = 1;
        while (!ov2 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("w256_lat", lat, 65);
        check_eq("w256_res", res2, 256'd1);
        check_eq("w256_err", err2, 1'b0);
        @(negedge clk); or2 = 1'b1;
        @(posedge clk); #1; or2 = 1'b0;
        check_eq("w256_rdy", ir2, 1'b1);

        @(negedge clk);
        n2 = '0; iv2 = 1'b1;
        @(posedge clk); #1; iv2 = 1'b0;
        check_eq("w256_n0_ov", ov2, 1'b1);
        check_eq("w256_n0_err", err2, 1'b1);
        check_eq("w256_n0_res", res2, 256'd0);
        @(negedge clk); or2 = 1'b1;
        @(posedge clk); #1; or2 = 1'b0;

        // ---- randomized, four ITERS values in parallel ----
        for (int it = 0; it < 1000; it++) begin
            int seen [4];
            int itv  [4];
            int keff;
            logic [15:0] nv, av, bv;
            logic [10:0] kv;
            itv = '{1, 3, 4, 8};
            nv = 16'($urandom);
            if (nv == 16'd0) nv = 16'd1;
            bv = 16'($urandom % 32'(nv));
            av = 16'($urandom);
            if ($urandom_range(0, 7) == 0) kv = 11'($urandom_range(16, 2047));
            else                           kv = 11'($urandom_range(0, 15));
            keff = (int'(kv) > 15) ? 15 : int'(kv);

            @(negedge clk);
            nr = nv; ar = av; br = bv; kr = kv; ivr = 1'b1;
            @(posedge clk); #1; ivr = 1'b0;
            seen = '{0, 0, 0, 0};
            for (int c = 1; c <= 40; c++) begin
                for (int g = 0; g < 4; g++)
                    if (ovr[g] && seen[g] == 0) seen[g] = c;
                if (seen[0] != 0 && seen[1] != 0 && seen[2] != 0 && seen[3] != 0) break;
                @(posedge clk); #1;
            end
            for (int g = 0; g < 4; g++) begin
                check_eq($sformatf("rnd%0d_it%0d_lat", it, itv[g]), seen[g],
                         (keff + itv[g]) / itv[g] + 1);
                check_eq($sformatf("rnd%0d_it%0d_res", it, itv[g]), resr[g],
                         16'(ref_mod(64'(av), 64'(bv), 64'(nv), int'(kv), 16)));
                check_eq($sformatf("rnd%0d_it%0d_err", it, itv[g]), errr[g], 1'b0);
            end
            @(negedge clk); orr = 1'b1;
            @(posedge clk); #1; orr = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
